// File: rtl/jtframe_joyser.sv
// jtframe_joyser: serial joystick reader for chained 74HC165-style pads with debounce and OSD combo
module jtframe_joyser #(
  parameter int NJOY = 2,
  parameter int JBITS = 16,
  parameter int CLKDIV = 8,
  parameter int INVERT = 1,
  parameter int DEBOUNCE = 1,
  parameter logic [15:0] COMBO_MASK = 16'h0440
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    JOY_DATA,
  output logic                    JOY_CLK,
  output logic                    JOY_LOAD,
  output logic [NJOY*JBITS-1:0]   joystick,
  output logic                    frame_done,
  output logic                    combo
);
  localparam int NB = NJOY * JBITS;
  localparam int CW = $clog2(CLKDIV);
  localparam int IW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] sync;
  logic [IW-1:0] idx;
  logic [NB-1:0] raw, last, joy_new;
  logic [2:0] dcnt, dcnt_new;
  logic tick, ph, upd, combo_new;
  always_comb begin
    tick = cnt == CW'(CLKDIV - 1);
    dcnt_new = raw != last ? 3'd1 : dcnt == 3'd7 ? 3'd7 : dcnt + 3'd1;
    upd = int'(dcnt_new) >= DEBOUNCE;
    joy_new = INVERT != 0 ? ~raw : raw;
    combo_new = &(joy_new[JBITS-1:0] | ~COMBO_MASK[JBITS-1:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sync <= '0;
      state <= IDLE;
      ph <= 1'b0;
      idx <= '0;
      raw <= '0;
      last <= '1;
      dcnt <= '0;
      joystick <= '0;
      combo <= 1'b0;
      frame_done <= 1'b0;
      JOY_CLK <= 1'b0;
      JOY_LOAD <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      sync <= {sync[0], JOY_DATA};
      frame_done <= 1'b0;
      case (state)
        IDLE: if (tick && enable) begin
          state <= LOAD;
          JOY_LOAD <= 1'b0;
        end
        LOAD: if (tick) begin
          ph <= !ph;
          if (ph) begin
            state <= SHIFT;
            JOY_LOAD <= 1'b1;
            idx <= '0;
          end
        end
        SHIFT: if (tick) begin
          ph <= !ph;
          JOY_CLK <= !ph;
          if (!ph) raw[idx] <= sync[1];
          else if (idx == IW'(NB - 1)) state <= LATCH;
          else idx <= idx + 1'b1;
        end
        LATCH: begin
          dcnt <= dcnt_new;
          last <= raw;
          if (upd) begin
            joystick <= joy_new;
            combo <= combo_new;
          end
          frame_done <= 1'b1;
          state <= enable ? LOAD : IDLE;
          JOY_LOAD <= !enable;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
